// File: rtl/axi_st_h2h_patgen_top_if.sv
// AXI-Stream transmit channel between the H2H pattern generator and the link.
// The master drives the data and valid signals; the slave drives ready.
interface axi_st_h2h_patgen_top_if #(
  parameter int unsigned AXI_CHNL_NUM = 4
) ();

  logic [64*AXI_CHNL_NUM-1:0] axist_tx_data;
  logic                       axist_tx_tvalid;
  logic                       axist_tx_tready;

  modport master (
    output axist_tx_data,
    output axist_tx_tvalid,
    input  axist_tx_tready
  );

  modport slave (
    input  axist_tx_data,
    input  axist_tx_tvalid,
    output axist_tx_tready
  );

endinterface

// File: rtl/axi_st_h2h_patgen_top.sv
// AXI-Stream simplex pattern generator feeding the H2H pattern checker.
// Sends a burst or a continuous stream of deterministic words. Every accepted word
// is mirrored into the checker's expected-data FIFO.
// Optional feature macro: AXIST_PATGEN_PRBS_EN builds per-lane PRBS LFSRs
// (x^31 + x^28 + 1). Without it the pattern is always incrementing.
module axi_st_h2h_patgen_top #(
  parameter int unsigned AXI_CHNL_NUM = 4
) (
  input  logic                        wrclk,
  input  logic                        rst_n,
  input  logic                        patgen_en,
  input  logic [8:0]                  patgen_cnt,
  input  logic                        cntuspatt_en,
  input  logic                        patgen_mode,
  axi_st_h2h_patgen_top_if.master     axist_tx,
  input  logic                        chkr_fifo_full,
  output logic [64*AXI_CHNL_NUM-1:0]  patgen_din,
  output logic                        patgen_din_wr,
  output logic [8:0]                  patgen_sent_cnt,
  output logic                        patgen_busy,
  output logic                        patgen_done,
  output logic                        patgen_ovf
);

  localparam int unsigned DW = 64 * AXI_CHNL_NUM;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic        patgen_en_q, cntus_en_q;
  logic        cont_q, stop_q, ovf_q;
  logic        tvalid_q, tvalid_d;
  logic [8:0]  rem_q, sent_q;
  logic [31:0] idx_q;
  logic        start_burst, start_cont, start, cont_fall, stop_now, accept, owed_next;
  logic        use_prbs;
  logic [DW-1:0] pat_data, tx_data;

  assign start_burst = patgen_en & ~patgen_en_q;
  assign start_cont  = cntuspatt_en & ~cntus_en_q;
  assign start       = (state_q == StIdle) & (start_burst | start_cont);
  assign cont_fall   = ~cntuspatt_en & cntus_en_q;
  // Stop request includes the falling edge seen this very cycle
  assign stop_now    = cont_q & (stop_q | cont_fall);
  assign accept      = tvalid_q & axist_tx.axist_tx_tready;

  // Whether another word is owed once this cycle's accept (if any) is counted
  always_comb begin
    owed_next = 1'b0;
    if (cont_q) begin
      owed_next = ~stop_now;
    end else if (accept) begin
      owed_next = (rem_q > 9'd1);
    end else begin
      owed_next = (rem_q != 9'd0);
    end
  end

  // FSM next state and transmit valid
  always_comb begin
    state_d  = state_q;
    tvalid_d = tvalid_q;
    unique case (state_q)
      StIdle: begin
        tvalid_d = 1'b0;
        if (start) state_d = StRun;
      end
      StRun: begin
        if (tvalid_q && !axist_tx.axist_tx_tready) begin
          // A raised beat is held until the handshake, even if the checker fills up
          tvalid_d = 1'b1;
        end else if (!owed_next) begin
          tvalid_d = 1'b0;
          state_d  = StDone;
        end else begin
          tvalid_d = ~chkr_fifo_full;
        end
      end
      StDone: begin
        tvalid_d = 1'b0;
        state_d  = StIdle;
      end
      default: begin
        tvalid_d = 1'b0;
        state_d  = StIdle;
      end
    endcase
  end

  // FSM state, edge-detect copies and transmit valid
  always_ff @(posedge wrclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      tvalid_q    <= 1'b0;
      patgen_en_q <= 1'b0;
      cntus_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tvalid_q    <= tvalid_d;
      patgen_en_q <= patgen_en;
      cntus_en_q  <= cntuspatt_en;
    end
  end

  // Burst bookkeeping: remaining/sent counters, word index, mode and overflow flags
  always_ff @(posedge wrclk or negedge rst_n) begin
    if (!rst_n) begin
      cont_q <= 1'b0;
      stop_q <= 1'b0;
      rem_q  <= 9'd0;
      sent_q <= 9'd0;
      idx_q  <= 32'd0;
      ovf_q  <= 1'b0;
    end else if (start) begin
      cont_q <= start_cont;
      stop_q <= 1'b0;
      rem_q  <= patgen_cnt;
      sent_q <= 9'd0;
      idx_q  <= 32'd0;
      ovf_q  <= 1'b0;
    end else begin
      if (state_q == StRun && cont_fall) stop_q <= 1'b1;
      if (accept) begin
        sent_q <= sent_q + 9'd1;
        idx_q  <= idx_q + 32'd1;
        if (!cont_q) rem_q <= rem_q - 9'd1;
        if (chkr_fifo_full) ovf_q <= 1'b1;
      end
    end
  end

`ifdef AXIST_PATGEN_PRBS_EN
  logic [31:0] lfsr_q [AXI_CHNL_NUM];
  logic        mode_q;

  assign use_prbs = mode_q;

  // Per-lane Fibonacci LFSRs, reseeded on start and stepped once per accept
  always_ff @(posedge wrclk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
      for (int k = 0; k < AXI_CHNL_NUM; k++) lfsr_q[k] <= 32'd1 + 32'(k);
    end else if (start) begin
      mode_q <= patgen_mode;
      for (int k = 0; k < AXI_CHNL_NUM; k++) lfsr_q[k] <= 32'd1 + 32'(k);
    end else if (accept) begin
      for (int k = 0; k < AXI_CHNL_NUM; k++) begin
        lfsr_q[k] <= {lfsr_q[k][30:0], lfsr_q[k][30] ^ lfsr_q[k][27]};
      end
    end
  end
`else
  logic unused_mode;

  assign unused_mode = patgen_mode;
  assign use_prbs    = 1'b0;
`endif

  // Build the current word from the index (or LFSRs); stable until accepted
  always_comb begin
    pat_data = '0;
    for (int k = 0; k < AXI_CHNL_NUM; k++) begin
      pat_data[64*k +: 64] = {8'(k), 24'hC0FFEE, idx_q};
`ifdef AXIST_PATGEN_PRBS_EN
      if (use_prbs) pat_data[64*k +: 64] = {lfsr_q[k], ~lfsr_q[k]};
`endif
    end
  end

  // Data is zero when no beat is offered so outputs read 0 out of reset
  assign tx_data                  = tvalid_q ? pat_data : '0;
  assign axist_tx.axist_tx_data   = tx_data;
  assign axist_tx.axist_tx_tvalid = tvalid_q;

  assign patgen_din_wr   = accept;
  assign patgen_din      = accept ? tx_data : '0;
  assign patgen_sent_cnt = sent_q;
  assign patgen_busy     = (state_q == StRun);
  assign patgen_done     = (state_q == StDone);
  assign patgen_ovf      = ovf_q;

endmodule

// File: tb/tb_axi_st_h2h_patgen_top.sv
// Self-checking bench for the H2H AXI-Stream pattern generator.
// Expected words are queued when a start is driven and popped on each FIFO push.
module tb_axi_st_h2h_patgen_top;

  localparam int unsigned NCH = 4;
  localparam int unsigned DW  = 64 * NCH;

  logic          wrclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          patgen_en = 1'b0;
  logic [8:0]    patgen_cnt = '0;
  logic          cntuspatt_en = 1'b0;
  logic          patgen_mode = 1'b0;
  logic          chkr_fifo_full = 1'b0;
  logic [DW-1:0] patgen_din;
  logic          patgen_din_wr;
  logic [8:0]    patgen_sent_cnt;
  logic          patgen_busy, patgen_done, patgen_ovf;

  axi_st_h2h_patgen_top_if #(.AXI_CHNL_NUM(NCH)) tx_if ();

  axi_st_h2h_patgen_top #(.AXI_CHNL_NUM(NCH)) dut (
    .wrclk           (wrclk),
    .rst_n           (rst_n),
    .patgen_en       (patgen_en),
    .patgen_cnt      (patgen_cnt),
    .cntuspatt_en    (cntuspatt_en),
    .patgen_mode     (patgen_mode),
    .axist_tx        (tx_if),
    .chkr_fifo_full  (chkr_fifo_full),
    .patgen_din      (patgen_din),
    .patgen_din_wr   (patgen_din_wr),
    .patgen_sent_cnt (patgen_sent_cnt),
    .patgen_busy     (patgen_busy),
    .patgen_done     (patgen_done),
    .patgen_ovf      (patgen_ovf)
  );

  always #5 wrclk = ~wrclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int edge_cyc = 0;
  int acc_cnt, done_cnt, tvalid_seen, first_valid_cyc, first_acc_cyc, last_acc_cyc, done_cyc;
  bit rdy_toggle = 1'b0;
  logic [DW-1:0] exp_q [$];
  logic [63:0]   lane0_log [$];

  typedef struct {
    int cnt;
    bit mode;
    bit toggle;
  } vec_t;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic reset_mon();
    acc_cnt = 0; done_cnt = 0; tvalid_seen = 0;
    first_valid_cyc = -1; first_acc_cyc = -1; last_acc_cyc = -1; done_cyc = -1;
    lane0_log.delete();
  endtask

  // Reference model of the expected word stream from a fresh start
  task automatic push_exp(input int n, input bit mode);
    logic [31:0] l [NCH];
    logic [DW-1:0] w;
    bit prbs;
`ifdef AXIST_PATGEN_PRBS_EN
    prbs = mode;
`else
    prbs = 1'b0;
    if (mode) prbs = 1'b0;
`endif
    for (int k = 0; k < NCH; k++) l[k] = 32'(k + 1);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < NCH; k++) begin
        if (prbs) w[64*k +: 64] = {l[k], ~l[k]};
        else      w[64*k +: 64] = {8'(k), 24'hC0FFEE, 32'(i)};
        l[k] = (l[k] << 1) | (((l[k] >> 30) ^ (l[k] >> 27)) & 32'd1);
      end
      exp_q.push_back(w);
    end
  endtask

  task automatic tick();
    @(posedge wrclk); #1;
  endtask

  task automatic start_burst(input int cnt, input bit mode);
    tick();
    patgen_cnt = 9'(cnt); patgen_mode = mode; patgen_en = 1'b1; edge_cyc = cyc;
    reset_mon();
    push_exp(cnt, mode);
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge wrclk);
      if (patgen_done) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s: got no done pulse within %0d cycles, expected one", name, budget);
    end
  endtask

  always @(posedge wrclk) cyc <= cyc + 1;

  // tready driver for the backpressure pattern
  initial forever begin
    @(posedge wrclk); #1;
    if (rdy_toggle) tx_if.axist_tx_tready = ~tx_if.axist_tx_tready;
  end

  // Monitor / scoreboard: sampled on the falling edge, away from the active edge
  initial begin
    bit prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [DW-1:0] e;
    forever begin
      @(negedge wrclk);
      if (rst_n) begin
        if (tx_if.axist_tx_tvalid) begin
          tvalid_seen++;
          if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        if (prev_hold) begin
          check("hold_tvalid", DW'(tx_if.axist_tx_tvalid), DW'(1));
          check("hold_data", tx_if.axist_tx_data, prev_data);
        end
        if (patgen_din_wr || (tx_if.axist_tx_tvalid && tx_if.axist_tx_tready))
          check("din_wr_vs_handshake", DW'(patgen_din_wr),
                DW'(tx_if.axist_tx_tvalid & tx_if.axist_tx_tready));
        if (patgen_din_wr) begin
          acc_cnt++;
          if (first_acc_cyc < 0) first_acc_cyc = cyc;
          last_acc_cyc = cyc;
          lane0_log.push_back(patgen_din[63:0]);
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_underflow: got word %h, expected none", patgen_din);
          end else begin
            e = exp_q.pop_front();
            check("din", patgen_din, e);
            check("tx_data", tx_if.axist_tx_data, e);
          end
        end
        if (patgen_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        prev_hold = tx_if.axist_tx_tvalid & ~tx_if.axist_tx_tready;
        prev_data = tx_if.axist_tx_data;
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  initial begin
    vec_t vecs [5];
    int   acc_before;
    bit   got;
    vecs[0] = '{cnt: 8, mode: 1'b0, toggle: 1'b0};
    vecs[1] = '{cnt: 4, mode: 1'b0, toggle: 1'b1};
    vecs[2] = '{cnt: 0, mode: 1'b0, toggle: 1'b0};
    vecs[3] = '{cnt: 1, mode: 1'b0, toggle: 1'b1};
    vecs[4] = '{cnt: 5, mode: 1'b1, toggle: 1'b0};
    tx_if.axist_tx_tready = 1'b1;
    reset_mon();

    // Reset state
    repeat (3) @(negedge wrclk);
    check("rst_tvalid", DW'(tx_if.axist_tx_tvalid), '0);
    check("rst_data", tx_if.axist_tx_data, '0);
    check("rst_din", patgen_din, '0);
    check("rst_flags", DW'({patgen_din_wr, patgen_busy, patgen_done, patgen_ovf}), '0);
    check("rst_sent", DW'(patgen_sent_cnt), '0);
    tick(); rst_n = 1'b1;
    repeat (2) tick();

    // Table-driven bursts
    for (int v = 0; v < 5; v++) begin
      tx_if.axist_tx_tready = 1'b1;
      rdy_toggle = vecs[v].toggle;
      start_burst(vecs[v].cnt, vecs[v].mode);
      @(negedge wrclk);
      @(negedge wrclk);
      check($sformatf("v%0d_busy", v), DW'(patgen_busy), DW'(1));
      wait_done(100, $sformatf("v%0d_done", v));
      check($sformatf("v%0d_busy_at_done", v), DW'(patgen_busy), '0);
      patgen_en = 1'b0; rdy_toggle = 1'b0;
      repeat (3) @(negedge wrclk);
      check($sformatf("v%0d_accepts", v), DW'(acc_cnt), DW'(vecs[v].cnt));
      check($sformatf("v%0d_sent", v), DW'(patgen_sent_cnt), DW'(vecs[v].cnt));
      check($sformatf("v%0d_done_pulses", v), DW'(done_cnt), DW'(1));
      check($sformatf("v%0d_sb_empty", v), DW'(exp_q.size()), '0);
      if (vecs[v].cnt == 0) begin
        check($sformatf("v%0d_no_tvalid", v), DW'(tvalid_seen), '0);
      end else begin
        check($sformatf("v%0d_first_valid_lat", v), DW'(first_valid_cyc - edge_cyc), DW'(2));
        check($sformatf("v%0d_done_lat", v), DW'(done_cyc - last_acc_cyc), DW'(1));
      end
      if (v == 0) begin
        check("v0_lane0_beat0", DW'(lane0_log[0]), DW'(64'h00C0FFEE_00000000));
        check("v0_back_to_back", DW'(last_acc_cyc - first_acc_cyc), DW'(7));
      end
      exp_q.delete();
    end

    // Continuous mode: wrap past 511, then stop while a beat is held
    tx_if.axist_tx_tready = 1'b1;
    tick();
    cntuspatt_en = 1'b1;
    reset_mon();
    push_exp(700, 1'b0);
    repeat (600) tick();
    tx_if.axist_tx_tready = 1'b0;
    tick();
    cntuspatt_en = 1'b0;
    repeat (3) tick();
    @(negedge wrclk);
    check("cont_held_tvalid", DW'(tx_if.axist_tx_tvalid), DW'(1));
    check("cont_held_busy", DW'(patgen_busy), DW'(1));
    acc_before = acc_cnt;
    tick();
    tx_if.axist_tx_tready = 1'b1;
    wait_done(10, "cont_done");
    check("cont_held_completes", DW'(acc_cnt), DW'(acc_before + 1));
    check("cont_wrapped", DW'(acc_cnt > 511), DW'(1));
    check("cont_sent_mod512", DW'(patgen_sent_cnt), DW'(acc_cnt % 512));
    check("cont_done_pulses", DW'(done_cnt), DW'(1));
    exp_q.delete();
    repeat (2) tick();

    // Checker full with no beat pending: nothing raised until it clears
    chkr_fifo_full = 1'b1;
    start_burst(3, 1'b0);
    repeat (10) @(negedge wrclk);
    check("full_no_tvalid", DW'(tvalid_seen), '0);
    check("full_busy", DW'(patgen_busy), DW'(1));
    tick();
    chkr_fifo_full = 1'b0;
    wait_done(20, "full_release_done");
    patgen_en = 1'b0;
    @(negedge wrclk);
    check("full_accepts", DW'(acc_cnt), DW'(3));
    check("full_no_ovf", DW'(patgen_ovf), '0);

    // Checker full while a beat is held, then accepted: sticky overflow
    tx_if.axist_tx_tready = 1'b0;
    start_burst(2, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge wrclk);
      if (tx_if.axist_tx_tvalid) got = 1'b1;
    end
    check("ovf_beat_raised", DW'(got), DW'(1));
    tick();
    chkr_fifo_full = 1'b1;
    tick();
    tx_if.axist_tx_tready = 1'b1;
    tick();
    chkr_fifo_full = 1'b0;
    wait_done(20, "ovf_done");
    patgen_en = 1'b0;
    repeat (5) @(negedge wrclk);
    check("ovf_sticky", DW'(patgen_ovf), DW'(1));
    check("ovf_accepts", DW'(acc_cnt), DW'(2));
    start_burst(1, 1'b0);
    @(negedge wrclk);
    @(negedge wrclk);
    check("ovf_cleared_on_start", DW'(patgen_ovf), '0);
    wait_done(20, "ovf_restart_done");
    patgen_en = 1'b0;
    repeat (2) tick();

`ifdef AXIST_PATGEN_PRBS_EN
    // PRBS lane 0 sequence from seed 1
    start_burst(3, 1'b1);
    wait_done(20, "prbs_done");
    patgen_en = 1'b0;
    @(negedge wrclk);
    check("prbs_count", DW'(lane0_log.size()), DW'(3));
    if (lane0_log.size() == 3) begin
      check("prbs_w0", DW'(lane0_log[0]), DW'(64'h00000001_FFFFFFFE));
      check("prbs_w1", DW'(lane0_log[1]), DW'(64'h00000002_FFFFFFFD));
      check("prbs_w2", DW'(lane0_log[2]), DW'(64'h00000004_FFFFFFFB));
    end
    patgen_mode = 1'b0;
    repeat (2) tick();
`endif

    // Reset mid-burst drops tvalid and returns to idle at once
    start_burst(20, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge wrclk);
      if (acc_cnt >= 3) got = 1'b1;
    end
    check("midrst_running", DW'(got), DW'(1));
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_tvalid", DW'(tx_if.axist_tx_tvalid), '0);
    check("midrst_busy", DW'(patgen_busy), '0);
    exp_q.delete();
    patgen_en = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    @(negedge wrclk);
    check("midrst_sent", DW'(patgen_sent_cnt), '0);
    check("midrst_flags", DW'({patgen_done, patgen_ovf, patgen_din_wr}), '0);
    repeat (3) @(negedge wrclk);
    check("midrst_stays_idle", DW'({tx_if.axist_tx_tvalid, patgen_busy}), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_st_h2h_patgen_top.md
# axi_st_h2h_patgen_top

AXIST simplex pattern generator. It sits directly upstream of the H2H pattern checker. It drives a burst or a continuous stream of deterministic AXI_CHNL_NUM×64-bit words onto the AXIST transmit interface. For every word accepted by the link, it pushes an identical copy into the checker's expected-data FIFO and reports the running word count for the checker's end-of-test compare.

## Interface
- AXI_CHNL_NUM, 4, number of 64-bit lanes per beat
- wrclk  in  1  single clock for all logic
- rst_n  in  1  asynchronous active-low reset
- patgen_en  in  1  burst start; rising edge launches a burst of patgen_cnt words
- patgen_cnt  in  9  burst length, sampled on the start edge
- cntuspatt_en  in  1  continuous mode; rising edge starts, falling edge stops
- patgen_mode  in  1  0 = incrementing pattern, 1 = PRBS (only with macro)
- axist_tx_data  out  64*AXI_CHNL_NUM  transmit data
- axist_tx_tvalid  out  1  transmit valid
- axist_tx_tready  in  1  link ready
- chkr_fifo_full  in  1  checker expected-FIFO full
- patgen_din  out  64*AXI_CHNL_NUM  copy of accepted word
- patgen_din_wr  out  1  one-cycle push per accepted word
- patgen_sent_cnt  out  9  words accepted since last start, wraps mod 512
- patgen_busy  out  1  high in RUN
- patgen_done  out  1  one-cycle pulse on entering DONE
- patgen_ovf  out  1  sticky: a word was accepted while chkr_fifo_full=1

## Operation
- FSM states and transitions:
  - IDLE -> RUN on a start edge.
  - RUN -> DONE when the burst count is exhausted, or continuous mode is stopped with no beat pending.
  - DONE -> IDLE after one cycle.
- Start edges are detected against a 1-cycle registered copy of patgen_en and cntuspatt_en. Edges seen outside IDLE are ignored.
- Start priority: if both rise in the same cycle, continuous mode wins.
- On start:
  - the remaining counter loads patgen_cnt;
  - patgen_sent_cnt clears;
  - the word index and LFSRs reload;
  - patgen_ovf clears.
- Burst mode with patgen_cnt=0: go RUN -> DONE with no beat and patgen_sent_cnt=0.
- tvalid rules:
  - tvalid rises only in RUN, while a word is owed and chkr_fifo_full=0.
  - Once high, tvalid and data are held until the handshake, regardless of chkr_fifo_full.
- Handshake: an accept is tvalid & tready. Each accept triggers, in the same cycle:
  - patgen_din_wr=1 and patgen_din=axist_tx_data;
  - patgen_sent_cnt+1 (mod 512);
  - the remaining counter −1 (burst mode only);
  - the pattern advances.
- If chkr_fifo_full=1 at the accept, the word is still pushed and patgen_ovf sets; it stays set until the next start or reset.
- Continuous-mode stop: on the cntuspatt_en falling edge, no new beat is raised. A held beat still completes, then the FSM enters DONE.
- patgen_en falling during RUN is ignored. Abort is by reset only.
- Incrementing pattern: lane k = {k[7:0], 24'hC0FFEE, word_idx[31:0]}. word_idx starts at 0 and wraps mod 2^32.
- PRBS pattern:
  - Per-lane 32-bit LFSR, polynomial x^31+x^28+1, seed 32'h0000_0001+k.
  - Lane k = {lfsr_k, ~lfsr_k}; advance one step per accept.

## Timing
- Reset values: all outputs 0. FSM = IDLE; counters, LFSR seeds and registered edge copies are loaded as on start.
- Start latency:
  - Start edge at input in cycle N: the registered copy detects it and the FSM is RUN in N+1.
  - tvalid is first high in N+2, if chkr_fifo_full=0.
- Back-to-back: with tready held high, one word per cycle and no bubbles.
- patgen_din_wr/patgen_din are combinational from the accept; patgen_sent_cnt updates the cycle after the accept.
- patgen_done pulses the cycle after the final accept. patgen_busy drops in that same cycle.
- A reset mid-burst returns the block to IDLE immediately and deasserts tvalid asynchronously.

## Configuration
- AXIST_PATGEN_PRBS_EN defined: the PRBS LFSRs are built and patgen_mode selects the pattern.
- AXIST_PATGEN_PRBS_EN undefined: no LFSR logic; patgen_mode is ignored and the pattern is always incrementing.

## Test plan
- Burst: patgen_cnt=8, incrementing mode, tready=1 → 8 consecutive beats starting 2 cycles after the edge; lane 0 of beat 0 = 64'h00C0FFEE_00000000; patgen_sent_cnt=8; one patgen_done pulse; 8 patgen_din_wr pulses.
- Backpressure:
  - Stimulus: patgen_cnt=4, tready toggled 1/0 every cycle.
  - Required: tvalid and data are stable while tready=0; exactly 4 accepts; data matches word_idx 0..3.
- Zero length: patgen_cnt=0 → no tvalid; patgen_done pulses; patgen_sent_cnt=0.
- Continuous: cntuspatt_en high for 600 cycles with tready=1.
  - Stimulus: cntuspatt_en drops while a beat is held.
  - Required: patgen_sent_cnt wraps past 511; the held beat completes; then DONE.
- Checker full:
  - Stimulus: chkr_fifo_full asserts with no beat pending.
  - Required: no new tvalid.
  - Stimulus: chkr_fifo_full asserts while a beat is held and then accepted.
  - Required: patgen_ovf=1 until the next start.
- PRBS (macro on): patgen_mode=1, 3 beats → lane 0 words {32'h1,~32'h1}, then the next two LFSR states; reset mid-burst → tvalid=0 and FSM in IDLE immediately.
